// File: rtl/shift_pkg.sv
// Shared types and constants for the shift writeback stage.
// The entry struct is the unit that moves through the two-deep skid buffer,
// and makeEntry is where the capture rules live so every load path agrees.
package shift_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              zero;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Builds an entry from raw shift_unit outputs. Writes to x0 are squashed
    // here so neither writeback nor forwarding ever sees a write to x0.
    function automatic entry_t makeEntry(
        input logic [DATA_W-1:0] sh,
        input logic [REG_AW-1:0] rd,
        input logic              we
    );
        entry_t e;
        e.data = sh;
        e.rd   = rd;
        e.we   = we & (rd != '0);
        e.zero = (sh == '0);
        return e;
    endfunction

endpackage

// File: rtl/shift_wb_entry.sv
// One storage slot of the writeback skid buffer.
// Holds a full entry; clear_i zeroes the contents and wins over load_i.
// Validity is tracked by the owning FSM, not here.
module shift_wb_entry
    import shift_pkg::*;
(
    input  logic   clk,
    input  logic   clear_i,
    input  logic   load_i,
    input  entry_t entry_i,
    output entry_t entry_o
);

    entry_t entry_q;

    // Capture a new entry when loaded; a clear wipes the slot back to zero.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            entry_q <= '0;
        end else if (load_i) begin
            entry_q <= entry_i;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/shift_wb_stage.sv
// Registered output stage behind shift_unit.
// MAIN drives the writeback port, SKID absorbs the one extra result that can
// arrive while writeback stalls, so in_ready can be a flop and still sustain
// one result per cycle. Forwarding exposes the youngest held result.
module shift_wb_stage
    import shift_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sh,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_we,
    output logic              out_zero,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data
);

    state_t state_q;
    state_t state_d;
    logic   inReady_q;

    logic   accept;
    logic   pop;
    logic   loadMain;
    logic   loadSkid;
    logic   clearEntries;
    entry_t newEntry;
    entry_t mainIn;
    entry_t mainEntry;
    entry_t skidEntry;
    entry_t fwdEntry;
    logic   fwdSelValid;

    assign out_valid    = (state_q != EMPTY);
    assign accept       = in_valid & inReady_q;
    assign pop          = out_valid & out_ready;
    assign newEntry     = makeEntry(in_sh, in_rd, in_we);
    assign clearEntries = ~rst_n;

    // Next-state and load decisions. Flush beats everything: nothing is
    // loaded and the buffer empties. In FULL in_ready is already low, so the
    // only event is a pop, which promotes SKID into MAIN.
    always_comb begin
        state_d  = state_q;
        loadMain = 1'b0;
        loadSkid = 1'b0;
        mainIn   = newEntry;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        loadMain = 1'b1;
                        state_d  = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        loadMain = 1'b1;
                    end else if (accept) begin
                        loadSkid = 1'b1;
                        state_d  = FULL;
                    end else if (pop) begin
                        state_d  = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        loadMain = 1'b1;
                        mainIn   = skidEntry;
                        state_d  = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and ready flop. in_ready is computed from the next state so it
    // is already correct on the cycle the buffer fills or drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            inReady_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            inReady_q <= (state_d != FULL);
        end
    end

    assign in_ready = inReady_q;

    shift_wb_entry uMain (
        .clk     (clk),
        .clear_i (clearEntries),
        .load_i  (loadMain),
        .entry_i (mainIn),
        .entry_o (mainEntry)
    );

    shift_wb_entry uSkid (
        .clk     (clk),
        .clear_i (clearEntries),
        .load_i  (loadSkid),
        .entry_i (newEntry),
        .entry_o (skidEntry)
    );

    assign out_data = mainEntry.data;
    assign out_rd   = mainEntry.rd;
    assign out_we   = mainEntry.we;
    assign out_zero = mainEntry.zero;

    // Forwarding picks the youngest held entry: SKID only holds data in FULL,
    // otherwise MAIN. With nothing held the forwarding bus reads all zero.
    always_comb begin
        fwdEntry    = (state_q == FULL) ? skidEntry : mainEntry;
        fwdSelValid = (state_q != EMPTY);
        fwd_valid   = fwdSelValid & fwdEntry.we;
        fwd_rd      = fwdSelValid ? fwdEntry.rd : '0;
        fwd_data    = fwdSelValid ? fwdEntry.data : '0;
    end

endmodule

// File: tb/tb_shift_wb_stage.sv
// Directed testbench for shift_wb_stage.
// Inputs change one time unit after each rising edge and outputs are checked
// one time unit after the edge that should have produced them.
module tb_shift_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_sh;
    logic [4:0]  in_rd;
    logic        in_we;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_zero;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    int testCount = 0;
    int failCount = 0;

    shift_wb_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sh     (in_sh),
        .in_rd     (in_rd),
        .in_we     (in_we),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_we    (out_we),
        .out_zero  (out_zero),
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A stalled entry must not change until writeback takes it, unless a
    // flush or reset squashes it at that edge.
    assert property (@(posedge clk)
        (rst_n && out_valid && !out_ready && !flush) |=>
        (out_valid && $stable(out_data) && $stable(out_rd) &&
         $stable(out_we) && $stable(out_zero)))
    else begin
        failCount++;
        $error("[TB] FAIL hold out_data=%0h out_valid=%0b", out_data, out_valid);
    end

    // Drive one cycle's worth of inputs.
    task automatic applyStimulus(
        input logic        valid,
        input logic [31:0] sh,
        input logic [4:0]  rd,
        input logic        we,
        input logic        ready,
        input logic        fl
    );
        in_valid  = valid;
        in_sh     = sh;
        in_rd     = rd;
        in_we     = we;
        out_ready = ready;
        flush     = fl;
    endtask

    // Advance past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One comparison against a bench-computed expected value.
    task automatic checkOutput(
        input string       tag,
        input logic [31:0] observed,
        input logic [31:0] expected
    );
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [31:0] val;

        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b1;

        checkOutput("reset_out_valid", out_valid, 32'd0);
        checkOutput("reset_in_ready", in_ready, 32'd1);
        checkOutput("reset_out_data", out_data, 32'd0);
        checkOutput("reset_fwd_valid", fwd_valid, 32'd0);

        applyStimulus(1'b1, 32'h0000_00F0, 5'd3, 1'b1, 1'b1, 1'b0);
        step();
        checkOutput("t1_out_valid", out_valid, 32'd1);
        checkOutput("t1_out_data", out_data, 32'h0000_00F0);
        checkOutput("t1_out_rd", out_rd, 32'd3);
        checkOutput("t1_out_we", out_we, 32'd1);
        checkOutput("t1_out_zero", out_zero, 32'd0);
        checkOutput("t1_fwd_valid", fwd_valid, 32'd1);
        checkOutput("t1_fwd_rd", fwd_rd, 32'd3);
        checkOutput("t1_fwd_data", fwd_data, 32'h0000_00F0);

        applyStimulus(1'b1, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0);
        step();
        checkOutput("t2_out_valid", out_valid, 32'd1);
        checkOutput("t2_out_we", out_we, 32'd0);
        checkOutput("t2_out_zero", out_zero, 32'd1);
        checkOutput("t2_fwd_valid", fwd_valid, 32'd0);

        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("t2_drain_out_valid", out_valid, 32'd0);

        applyStimulus(1'b1, 32'h1, 5'd1, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("t3_a_in_ready", in_ready, 32'd1);
        applyStimulus(1'b1, 32'h2, 5'd2, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("t3_full_in_ready", in_ready, 32'd0);
        checkOutput("t3_full_out_data", out_data, 32'h1);
        applyStimulus(1'b1, 32'h3, 5'd3, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("t3_c_held_in_ready", in_ready, 32'd0);
        checkOutput("t3_c_held_out_data", out_data, 32'h1);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("t3_pop_a_out_data", out_data, 32'h2);
        checkOutput("t3_pop_a_in_ready", in_ready, 32'd1);
        step();
        checkOutput("t3_pop_b_out_valid", out_valid, 32'd0);

        for (int i = 0; i < 100; i++) begin
            val = $urandom;
            applyStimulus(1'b1, val, 5'(i % 32), 1'b1, 1'b1, 1'b0);
            step();
            checkOutput("t4_out_data", out_data, val);
            checkOutput("t4_in_ready", in_ready, 32'd1);
        end
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("t4_drain_out_valid", out_valid, 32'd0);

        applyStimulus(1'b1, 32'h0000_AAAA, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'h0000_BBBB, 5'd7, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("t5_full_fwd_valid", fwd_valid, 32'd1);
        checkOutput("t5_full_fwd_rd", fwd_rd, 32'd7);
        checkOutput("t5_full_fwd_data", fwd_data, 32'h0000_BBBB);
        checkOutput("t5_full_out_rd", out_rd, 32'd5);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("t5_pop_out_rd", out_rd, 32'd7);
        checkOutput("t5_pop_fwd_rd", fwd_rd, 32'd7);
        checkOutput("t5_pop_fwd_data", fwd_data, 32'h0000_BBBB);
        applyStimulus(1'b1, 32'h0000_CCCC, 5'd9, 1'b1, 1'b0, 1'b1);
        step();
        checkOutput("t5_flush_out_valid", out_valid, 32'd0);
        checkOutput("t5_flush_fwd_valid", fwd_valid, 32'd0);
        checkOutput("t5_flush_in_ready", in_ready, 32'd1);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        checkOutput("t5_dropped_out_valid", out_valid, 32'd0);

        applyStimulus(1'b1, 32'h0000_DDDD, 5'd4, 1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'h0000_EEEE, 5'd6, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("t6_full_in_ready", in_ready, 32'd0);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        checkOutput("t6_rst_out_valid", out_valid, 32'd0);
        checkOutput("t6_rst_out_data", out_data, 32'd0);
        checkOutput("t6_rst_out_rd", out_rd, 32'd0);
        checkOutput("t6_rst_out_we", out_we, 32'd0);
        checkOutput("t6_rst_out_zero", out_zero, 32'd0);
        checkOutput("t6_rst_fwd_valid", fwd_valid, 32'd0);
        checkOutput("t6_rst_fwd_rd", fwd_rd, 32'd0);
        checkOutput("t6_rst_fwd_data", fwd_data, 32'd0);
        checkOutput("t6_rst_in_ready", in_ready, 32'd1);
        rst_n = 1'b1;
        step();
        checkOutput("t6_release_in_ready", in_ready, 32'd1);
        checkOutput("t6_release_out_valid", out_valid, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
